jtframe_sddac_multi: RTL

Parametrised multi-channel 1-bit sigma-delta audio DAC for the MiST-family targets. It generalises the fixed stereo, 16-bit, first-order DAC path of the target base module to N channels, configurable sample width, configurable oversampling clock-enable divider, and a selectable first- or second-order modulator. It sits between the core's sound outputs and the board's PWM audio pins and runs on the DAC clock.

---
 rtl/jtframe_sddac_multi_if.sv | 22 ++
 rtl/jtframe_sddac_multi.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/jtframe_sddac_multi_if.sv
// Sound bus between a core's audio outputs and the multi-channel sigma-delta DAC.
//
// Signals:
//   snd      packed samples, channel k at [k*WIDTH +: WIDTH]   (master -> slave)
//   mute     forces every modulator input to mid-scale          (master -> slave)
//   cen_out  one-cycle pulse marking each modulator update      (slave -> master)
//   dac      1-bit modulated outputs, one per channel           (slave -> master)
//
// Modports: master = sound source side, slave = DAC side.

interface jtframe_sddac_multi_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned WIDTH    = 16
);
   logic [CHANNELS*WIDTH-1:0] snd;
   logic                      mute;
   logic                      cen_out;
   logic [CHANNELS-1:0]       dac;

   modport master (output snd, output mute, input cen_out, input dac);
   modport slave  (input snd, input mute, output cen_out, output dac);
endinterface

// File: rtl/jtframe_sddac_multi.sv
// Parametrised multi-channel 1-bit sigma-delta audio DAC.
//
// Every channel runs its own first- or second-order modulator; all channels share one
// clock enable produced by a 0..CEN_DIV-1 divider and are updated in parallel.
//
// Ports:
//   clk  DAC clock, all logic on its rising edge
//   rst  synchronous, active-high reset
//   bus  jtframe_sddac_multi_if slave modport (snd, mute in; cen_out, dac out)
//
// Parameters: CHANNELS (1..8), WIDTH (8..24), CEN_DIV (1..256),
//   SIGNED_SND (1: two's complement, 0: offset binary), ORDER (1 or 2).
//
// Optional feature: define JTFRAME_SDDAC_DITHER_EN to add one bit of LFSR dither per
// channel ahead of the modulator (bypassed while muted). Without it the modulator input
// is the converted sample itself.

module jtframe_sddac_multi #(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned CEN_DIV    = 4,
   parameter int unsigned SIGNED_SND = 1,
   parameter int unsigned ORDER      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   jtframe_sddac_multi_if.slave bus
);

   localparam int unsigned   CW       = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CEN_DIV - 1);
   localparam logic [WIDTH-1:0] MID   = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CW-1:0] cnt_q;
   logic          cen;
   logic          cen_q;

   // With CEN_DIV=1 the counter is stuck at 0 and cen is permanently high.
   assign cen         = (cnt_q == CNT_LAST);
   assign bus.cen_out = cen_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         cen_q <= 1'b0;
      end else begin
         cnt_q <= cen ? '0 : cnt_q + 1'b1;
         cen_q <= cen;
      end
   end

`ifdef JTFRAME_SDDAC_DITHER_EN
   // Galois LFSR, x^16+x^14+x^13+x^11+1, one step per modulator update.
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else if (cen) begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [WIDTH-1:0] smp;
      logic [WIDTH-1:0] x_raw;
      logic [WIDTH-1:0] x;
      logic             dac_q;

      assign smp   = bus.snd[k*WIDTH +: WIDTH];
      // Flipping the MSB maps two's complement onto offset binary (mid-scale = MID).
      assign x_raw = (SIGNED_SND != 0) ? {~smp[WIDTH-1], smp[WIDTH-2:0]} : smp;

`ifdef JTFRAME_SDDAC_DITHER_EN
      logic [WIDTH:0] x_dith;

      assign x_dith = {1'b0, x_raw} + {{WIDTH{1'b0}}, lfsr_q[k % 16]};
      assign x      = bus.mute ? MID : (x_dith[WIDTH] ? {WIDTH{1'b1}} : x_dith[WIDTH-1:0]);
`else
      assign x      = bus.mute ? MID : x_raw;
`endif

      assign bus.dac[k] = dac_q;

      if (ORDER == 1) begin : g_o1
         logic [WIDTH:0] acc_q;
         logic [WIDTH:0] acc_d;

         // The carry out of the low WIDTH bits is the output bit; it is dropped next time.
         assign acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, x};

         always_ff @(posedge clk) begin
            if (rst) begin
               acc_q <= '0;
               dac_q <= 1'b0;
            end else if (cen) begin
               acc_q <= acc_d;
               dac_q <= acc_d[WIDTH];
            end
         end
      end else if (ORDER == 2) begin : g_o2
         localparam int unsigned IW = WIDTH + 3;
         localparam int unsigned SW = WIDTH + 5;

         logic signed [IW-1:0] i1_q, i2_q, i1_d, i2_d;
         logic signed [SW-1:0] fb, s1, s2;

         // Sums are formed two bits wider; they fit IW bits iff the top three bits agree.
         function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
            if (v[SW-1:IW-1] == {3{v[SW-1]}}) begin
               return v[IW-1:0];
            end
            return v[SW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
         endfunction

         always_comb begin
            fb         = '0;
            fb[WIDTH]  = dac_q;
            s1         = {{2{i1_q[IW-1]}}, i1_q} + $signed({5'b00000, x}) - fb;
            i1_d       = sat(s1);
            s2         = {{2{i2_q[IW-1]}}, i2_q} + {{2{i1_d[IW-1]}}, i1_d} - fb;
            i2_d       = sat(s2);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               i1_q  <= '0;
               i2_q  <= '0;
               dac_q <= 1'b0;
            end else if (cen) begin
               i1_q  <= i1_d;
               i2_q  <= i2_d;
               dac_q <= ~i2_d[IW-1];
            end
         end
      end else begin : g_bad_order
         $error("jtframe_sddac_multi: ORDER must be 1 or 2");
      end
   end

endmodule
